// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with a one-entry registered output stage and valid/ready.
// Define ALU_SEQ_SHIFT_EN to build the iterative one-bit-per-cycle SLL/SRL shifter.
module alu_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);
    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_carry;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res   = A;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        unique case (control)
            3'b000: begin
                alu_res   = sum[MSB:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            3'b001: begin
                alu_res   = diff[MSB:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            3'b010:  alu_res = A & B;
            3'b011:  alu_res = A | B;
            3'b100:  alu_res = A ^ B;
            3'b101:  alu_res = ~(A | B);
            // Shift opcodes pass A through: the unshifted result for shamt==0 or no shifter.
            default: alu_res = A;
        endcase
    end

    logic             accept, wr_en;
    logic [WIDTH-1:0] wr_res;
    logic             wr_ovf, wr_carry;

    assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_SHIFT_EN
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    typedef enum logic {StIdle, StShift} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d, shifted;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;

    assign shifted  = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
    assign in_ready = (state_q == StIdle) && (!out_valid || out_ready);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        wr_en    = 1'b0;
        wr_res   = alu_res;
        wr_ovf   = alu_ovf;
        wr_carry = alu_carry;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (control[2:1] == 2'b11) begin
                        shreg_d = A;
                        cnt_d   = B[SHAMT_W-1:0];
                        dir_d   = control[0];
                        if (B[SHAMT_W-1:0] == '0) wr_en = 1'b1;
                        else                      state_d = StShift;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            StShift: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    wr_en    = 1'b1;
                    wr_res   = shifted;
                    wr_ovf   = 1'b0;
                    wr_carry = 1'b0;
                    state_d  = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        wr_en    = accept;
        wr_res   = alu_res;
        wr_ovf   = alu_ovf;
        wr_carry = alu_carry;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            sticky_ovf <= 1'b0;
        end else begin
            if (wr_en) begin
                out       <= wr_res;
                overflow  <= wr_ovf;
                carry     <= wr_carry;
                zero      <= (wr_res == '0);
                negative  <= wr_res[MSB];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // A set in the same cycle as a clear takes priority.
            if (wr_en && wr_ovf) sticky_ovf <= 1'b1;
            else if (clr_sticky) sticky_ovf <= 1'b0;
        end
    end
endmodule
